// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the parameterised serial pattern detector.
package seq_det_pkg;

    localparam logic [7:0]  DEF_PAT = 8'b0000_0110;
    localparam int unsigned DEF_LEN = 3;

    // Width able to hold every value 0..max_len (fill counter and pattern length).
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Signal bundle for the detector: serial stream, configuration and match reporting.
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input logic clk
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic               data;
    logic               data_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               detected;
    logic               detected_q;
    logic [CNT_W-1:0]   match_count;

    modport master (
        input  clk,
        output data, data_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  detected, detected_q, match_count
    );

    modport slave (
        input  clk,
        input  data, data_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output detected, detected_q, match_count
    );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module seq_det_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control and a
// saturating match counter; the pattern is compared against a shift history.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seq_det_pkg::DEF_PAT),
    parameter int unsigned        DEF_LEN = seq_det_pkg::DEF_LEN,
    localparam int unsigned       LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data,
    input  logic               data_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               detected,
    output logic               detected_q,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic [MAX_LEN:0]   window;
    logic [MAX_LEN:0]   ones;
    logic [MAX_LEN:0]   win_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic [LEN_W-1:0]   len_clamped;
    logic               enough_bits;
    logic               bits_match;

    // Window holds the incoming bit at [0]; only the low len bits take part.
    always_comb begin
        window      = {hist, data};
        ones        = '1;
        win_mask    = ~(ones << len);
        fill_inc    = {1'b0, fill} + (LEN_W + 1)'(1);
        fill_sat    = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        enough_bits = (fill_inc >= {1'b0, len});
        bits_match  = (((window ^ {1'b0, pat}) & win_mask) == '0);
        detected    = rst_n && data_valid && !cfg_load && (len != '0)
                      && enough_bits && bits_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist       <= '0;
            fill       <= '0;
            pat        <= DEF_PAT;
            len        <= LEN_W'(DEF_LEN);
            ovl        <= 1'b1;
            detected_q <= 1'b0;
        end else begin
            detected_q <= detected;
            if (cfg_load) begin
                pat  <= cfg_pattern;
                len  <= len_clamped;
                ovl  <= cfg_overlap;
                fill <= '0;
            end else if (data_valid) begin
                hist <= {hist[MAX_LEN-2:0], data};
                // Non-overlapping mode restarts the fill so matched bits are not reused.
                fill <= (detected && !ovl) ? '0 : fill_sat;
            end
        end
    end

    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (detected),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, randomized stream against
// a queue-based reference model, and hand-written reset corner sequences.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus (.clk(clk));

    logic       det2;
    logic       dq2;
    logic [1:0] cnt2;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (bus.data),
        .data_valid  (bus.data_valid),
        .cfg_load    (bus.cfg_load),
        .cfg_pattern (bus.cfg_pattern),
        .cfg_len     (bus.cfg_len),
        .cfg_overlap (bus.cfg_overlap),
        .cnt_clr     (bus.cnt_clr),
        .detected    (bus.detected),
        .detected_q  (bus.detected_q),
        .match_count (bus.match_count)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (bus.data),
        .data_valid  (bus.data_valid),
        .cfg_load    (bus.cfg_load),
        .cfg_pattern (bus.cfg_pattern),
        .cfg_len     (bus.cfg_len),
        .cfg_overlap (bus.cfg_overlap),
        .cnt_clr     (bus.cnt_clr),
        .detected    (det2),
        .detected_q  (dq2),
        .match_count (cnt2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bits usable for a match, oldest first.
    bit          mq[$];
    logic [7:0]  mpat;
    int unsigned mlen;
    bit          movl;
    int          mcnt;
    int          mcnt2;
    bit          mdq;
    bit          last_det;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mpat  = 8'b0000_0110;
        mlen  = 3;
        movl  = 1'b1;
        mcnt  = 0;
        mcnt2 = 0;
        mdq   = 1'b0;
    endfunction

    // pat[len-1] is the oldest bit of the match, pat[0] the bit arriving now.
    function automatic bit model_match(input bit load, input bit v, input bit d);
        if (load || !v || mlen == 0) return 1'b0;
        if (mq.size() + 1 < mlen) return 1'b0;
        for (int unsigned i = 0; i < mlen; i++) begin
            bit b;
            b = (i == 0) ? d : mq[mq.size() - i];
            if (b != mpat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit load, input logic [7:0] pat, input int unsigned len,
                        input bit ovl, input bit v, input bit d, input bit clr);
        bit m;
        @(negedge clk);
        bus.cfg_load    = load;
        bus.cfg_pattern = pat;
        bus.cfg_len     = 4'(len);
        bus.cfg_overlap = ovl;
        bus.data_valid  = v;
        bus.data        = d;
        bus.cnt_clr     = clr;
        #1;
        m = model_match(load, v, d);
        last_det = bus.detected;
        check("detected", int'(bus.detected), int'(m));
        check("detected_small", int'(det2), int'(m));
        @(posedge clk);
        if (load) begin
            mpat = pat;
            mlen = (len > 8) ? 8 : len;
            movl = ovl;
            mq.delete();
        end else if (v) begin
            if (m && !movl) begin
                mq.delete();
            end else begin
                mq.push_back(d);
                if (mq.size() > 8) void'(mq.pop_front());
            end
        end
        if (clr) begin
            mcnt  = 0;
            mcnt2 = 0;
        end else if (m) begin
            mcnt  = (mcnt  < 255) ? mcnt + 1  : 255;
            mcnt2 = (mcnt2 < 3)   ? mcnt2 + 1 : 3;
        end
        mdq = m;
        #1;
        check("detected_q", int'(bus.detected_q), int'(mdq));
        check("match_count", int'(bus.match_count), mcnt);
        check("match_count_small", int'(cnt2), mcnt2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cnt_clr     = 1'b0;
        bus.data_valid  = 1'b1;
        bus.data        = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        #1;
        // Checked before any clock edge: reset must act asynchronously.
        check("rst_detected", int'(bus.detected), 0);
        check("rst_count", int'(bus.match_count), 0);
        check("rst_count_small", int'(cnt2), 0);
        check("rst_detected_q", int'(bus.detected_q), 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_hold_detected", int'(bus.detected), 0);
        rst_n          = 1'b1;
        bus.data_valid = 1'b0;
    endtask

    typedef struct {
        bit          load;
        logic [7:0]  pat;
        int unsigned len;
        bit          ovl;
        bit          v;
        bit          d;
        bit          clr;
        bit          exp_det;
        int          exp_cnt;
        int          exp_cnt2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit load, input logic [7:0] pat, input int unsigned len,
                                input bit ovl, input bit v, input bit d, input bit clr,
                                input bit exp_det, input int exp_cnt, input int exp_cnt2);
        vec_t r;
        r.load = load; r.pat = pat; r.len = len; r.ovl = ovl;
        r.v = v; r.d = d; r.clr = clr;
        r.exp_det = exp_det; r.exp_cnt = exp_cnt; r.exp_cnt2 = exp_cnt2;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data = 1'b0; bus.data_valid = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cnt_clr = 1'b0;

        // Defaults 110/len3/overlap: matches on bits 3 and 6
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 2, 2));
        // 1010/len4 overlapping: bits 4 and 6
        vecs.push_back(mk(1, 8'h0A, 4, 1, 0, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 3, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 4, 3));
        // 1010/len4 non-overlapping: bit 4 only
        vecs.push_back(mk(1, 8'h0A, 4, 0, 0, 0, 0, 0, 4, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 4, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 4, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 4, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 5, 3));
        // 110 with invalid gaps: only the valid final 0 matches
        vecs.push_back(mk(1, 8'h06, 3, 1, 0, 0, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 5, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 6, 3));
        // cnt_clr coincident with a match wins
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 6, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 6, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        // cfg_load on the final pattern bit: no match, fill restarts
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h06, 3, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 1));
        // len 0 disables detection
        vecs.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 1));
        // cfg_len above MAX_LEN clamps to 8: eight ones match on the eighth
        vecs.push_back(mk(1, 8'hFF, 15, 1, 0, 0, 0, 0, 1, 1));
        for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 2, 2));

        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].pat, vecs[i].len, vecs[i].ovl,
                 vecs[i].v, vecs[i].d, vecs[i].clr);
            check($sformatf("tbl%0d_det", i), int'(last_det), int'(vecs[i].exp_det));
            check($sformatf("tbl%0d_cnt", i), int'(bus.match_count), vecs[i].exp_cnt);
            check($sformatf("tbl%0d_cnt_small", i), int'(cnt2), vecs[i].exp_cnt2);
        end

        for (int n = 0; n < 800; n++) begin
            bit          ld;
            int unsigned ln;
            ld = ($urandom_range(0, 99) < 3);
            ln = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 4);
            step(ld, 8'($urandom), ln, 1'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 99) < 2));
        end

        // Reset mid-pattern: partial 1,1 must not combine with a later 0
        step(1, 8'h06, 3, 1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        do_reset();
        step(0, 8'h00, 0, 0, 1, 0, 0);
        check("post_rst_no_det", int'(last_det), 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0, 0);
        check("post_rst_first_det", int'(last_det), 1);
        check("post_rst_count", int'(bus.match_count), 1);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        check("post_rst_dq_pulse", int'(bus.detected_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have parameter DEF_PAT, default 8'b0000_0110: pattern loaded at reset.
REQ-004 SHALL have parameter DEF_LEN, default 3: pattern length loaded at reset.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port data, input, 1: serial data bit.
REQ-008 SHALL have port data_valid, input, 1: data is sampled only when this is high.
REQ-009 SHALL have port cfg_load, input, 1: one-cycle pulse that captures the configuration.
REQ-010 SHALL have port cfg_pattern, input, MAX_LEN: bit [len-1] is the first bit received and bit [0] is the last.
REQ-011 SHALL have port cfg_len, input, $clog2(MAX_LEN+1): pattern length.
REQ-012 SHALL have port cfg_overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-013 SHALL have port cnt_clr, input, 1: synchronous clear of match_count.
REQ-014 SHALL have port detected, output, 1: Mealy match flag, combinational.
REQ-015 SHALL have port detected_q, output, 1: detected registered once.
REQ-016 SHALL have port match_count, output, CNT_W: saturating count of matches.

Function
REQ-017 SHALL hold internal state: hist[MAX_LEN-1:0] shift register, fill counter (0..MAX_LEN), and captured config registers pat, len, ovl.
REQ-018 SHALL, on a cycle with data_valid=1 and no cfg_load, shift data into hist[0] (older bits move up) and set fill to min(fill+1, MAX_LEN).
REQ-019 SHALL drive detected=1 in the same cycle that data_valid=1, cfg_load=0, len!=0, fill+1>=len and {hist,data}[len-1:0]==pat[len-1:0]; otherwise detected=0.
REQ-020 SHALL keep detected=0 whenever data_valid=0; hist and fill hold on those cycles.
REQ-021 SHALL, when ovl=1, let a match leave hist and fill updated normally, so overlapping matches are reported.
REQ-022 SHALL, when ovl=0, set fill to 0 on the match edge so that no bit of a reported match is reused.
REQ-023 SHALL, on cfg_load, capture pat<=cfg_pattern, len<=min(cfg_len,MAX_LEN) and ovl<=cfg_overlap, and clear fill to 0.
REQ-024 SHALL give cfg_load priority over data_valid in the same cycle: the data bit is discarded and detected=0.
REQ-025 SHALL treat len==0 as disabled: detected is never asserted and shifting continues.
REQ-026 SHALL increment match_count by 1 on every edge where detected=1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL give cnt_clr priority over increment: the count becomes 0 even if detected=1 in that cycle.
REQ-028 SHALL update detected_q <= detected every edge, giving 1-cycle latency.

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk, set hist=0, fill=0, pat=DEF_PAT, len=DEF_LEN, ovl=1, match_count=0 and detected_q=0.
REQ-030 SHALL hold detected=0 while in reset.
REQ-031 SHALL require the first match after rst_n deassertion to use bits received after release.
REQ-032 SHALL, on reset asserted mid-pattern, discard the partial match with no residual detection.

Structure
REQ-033 SHALL place DEF_PAT, DEF_LEN and the fill/len width calculation in shared package seq_det_pkg.
REQ-034 SHALL instantiate one sub-module, seq_det_sat_cnt, a parametrised CNT_W saturating counter with inc, clr and rst_n inputs.
REQ-035 SHALL implement the history/compare logic inline; no per-pattern FSM encoding is allowed.

Verification
REQ-036 SHALL cover: defaults after reset, stream 1,1,0,1,1,0 -> detected high on bits 3 and 6, match_count=2, detected_q high one cycle after each.
REQ-037 SHALL cover: load pattern 4'b1010 with len=4 and ovl=1, stream 1,0,1,0,1,0 -> detected on bits 4 and 6, count=2.
REQ-038 SHALL cover: same pattern with ovl=0, stream 1,0,1,0,1,0 -> detected on bit 4 only, count=1.
REQ-039 SHALL cover: data_valid low between the bits of 1,1,0 -> detected only on the valid 0 bit, and never while valid is low.
REQ-040 SHALL cover: CNT_W=2 with 5 matches -> count saturates at 3; cnt_clr together with a match -> count=0.
REQ-041 SHALL cover: rst_n low after 1,1 then release, then 0 -> no detection; cfg_load coincident with the final pattern bit -> no detection and fill=0.
